weight_stream_sink: RTL and testbench



---
 rtl/weight_sink_pkg.sv | 16 +
 rtl/weight_stream_sink_ram.sv | 57 +++++
 rtl/weight_stream_sink.sv | 135 +++++++++++++
 tb/tb_weight_stream_sink.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sink_pkg.sv
// Shared types and helpers for the weight stream sink.
//   sink_state_t : fill controller states
//   clog2_min1   : address/counter width that never collapses to zero
package weight_sink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } sink_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_sink_ram.sv
// Simple dual-port word RAM: one write port, one read port with a 2-stage
// ce0-gated read pipeline (ROM-compatible address0/ce0/q0 interface).
//   clk, rst            : clock, async active-low reset (read pipeline only)
//   we, waddr, wdata    : write port
//   address0, ce0, q0   : read port, 2-cycle latency, read-first vs. write
module weight_stream_sink_ram
  import weight_sink_pkg::*;
#(
  parameter int unsigned DWIDTH   = 512,
  parameter int unsigned MEM_SIZE = 576,
  parameter int unsigned AWIDTH   = $clog2(MEM_SIZE) + 1,
  parameter int unsigned WAWIDTH  = clog2_min1(MEM_SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WAWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0]  address0,
  input  logic               ce0,
  output logic [DWIDTH-1:0]  q0
);

  logic [DWIDTH-1:0] mem [MEM_SIZE];
  logic [DWIDTH-1:0] rd_word_c;
  logic [DWIDTH-1:0] stage0;
  logic [DWIDTH-1:0] stage1;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return zero; the value is a don't-care for callers.
  always_comb begin
    rd_word_c = '0;
    if (address0 < AWIDTH'(MEM_SIZE)) begin
      rd_word_c = mem[address0[WAWIDTH-1:0]];
    end
  end

  // Read pipeline: both stages advance only with ce0, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage0 <= '0;
      stage1 <= '0;
    end else if (ce0) begin
      stage0 <= rd_word_c;
      stage1 <= stage0;
    end
  end

  assign q0 = stage1;

endmodule

// File: rtl/weight_stream_sink.sv
// Stream-to-memory weight loader. Packs valid/ready element beats into wide
// words and writes them sequentially into a RAM readable like a weight ROM.
//   clk, rst                         : clock, async active-low reset
//   data_in, data_in_valid/ready     : beat stream (element 0 -> word LSBs)
//   load_start                       : pulse, restart fill from word 0
//   load_done                        : all MEM_SIZE words written
//   address0, ce0, q0                : ROM-style read port, 2-cycle latency
module weight_stream_sink
  import weight_sink_pkg::*;
#(
  parameter int unsigned PRECISION_0       = 16,
  parameter int unsigned PARALLELISM_DIM_0 = 1,
  parameter int unsigned PARALLELISM_DIM_1 = 1,
  parameter int unsigned WORD_ELEMS        = 32,
  parameter int unsigned MEM_SIZE          = 576,
  parameter int unsigned AWIDTH            = $clog2(MEM_SIZE) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PRECISION_0-1:0]            data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  input  logic                              load_start,
  output logic                              load_done,
  input  logic [AWIDTH-1:0]                 address0,
  input  logic                              ce0,
  output logic [PRECISION_0*WORD_ELEMS-1:0] q0
);

  localparam int unsigned BEAT_ELEMS     = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int unsigned BEATS_PER_WORD = WORD_ELEMS / BEAT_ELEMS;
  localparam int unsigned DWIDTH         = PRECISION_0 * WORD_ELEMS;
  localparam int unsigned BCW            = clog2_min1(BEATS_PER_WORD);
  localparam int unsigned WAW            = clog2_min1(MEM_SIZE);

  sink_state_t       state_q;
  sink_state_t       state_d;
  logic [BCW-1:0]    beat_q;
  logic [WAW-1:0]    wr_addr_q;
  logic [DWIDTH-1:0] word_q;
  logic [DWIDTH-1:0] word_c;
  logic              ready_c;
  logic              accept_c;
  logic              last_beat_c;
  logic              last_word_c;
  logic              load_done_q;

  assign last_beat_c = (beat_q == BCW'(BEATS_PER_WORD - 1));
  assign last_word_c = (wr_addr_q == WAW'(MEM_SIZE - 1));

  // Next-state and handshake. load_start overrides everything and also
  // blocks the handshake in its own cycle, so a coincident beat is dropped.
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: ;
      FILL: begin
        ready_c  = !load_start;
        accept_c = data_in_valid && !load_start;
        if (accept_c && last_beat_c && last_word_c) begin
          state_d = FULL;
        end
      end
      FULL: ;
      default: state_d = IDLE;
    endcase
    if (load_start) begin
      state_d = FILL;
    end
  end

  // Word under construction with the current beat merged into slot beat_q.
  always_comb begin
    word_c = word_q;
    for (int unsigned k = 0; k < BEATS_PER_WORD; k++) begin
      if (beat_q == BCW'(k)) begin
        for (int unsigned j = 0; j < BEAT_ELEMS; j++) begin
          word_c[PRECISION_0*(k*BEAT_ELEMS+j) +: PRECISION_0] = data_in[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= (state_d == FULL);
    end
  end

  // Beat counter, assembly register and write address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q    <= '0;
      wr_addr_q <= '0;
      word_q    <= '0;
    end else if (load_start) begin
      beat_q    <= '0;
      wr_addr_q <= '0;
    end else if (accept_c) begin
      word_q <= word_c;
      if (last_beat_c) begin
        beat_q    <= '0;
        wr_addr_q <= last_word_c ? '0 : wr_addr_q + WAW'(1);
      end else begin
        beat_q <= beat_q + BCW'(1);
      end
    end
  end

  assign data_in_ready = ready_c;
  assign load_done     = load_done_q;

  weight_stream_sink_ram #(
    .DWIDTH  (DWIDTH),
    .MEM_SIZE(MEM_SIZE),
    .AWIDTH  (AWIDTH),
    .WAWIDTH (WAW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (accept_c && last_beat_c),
    .waddr   (wr_addr_q),
    .wdata   (word_c),
    .address0(address0),
    .ce0     (ce0),
    .q0      (q0)
  );

endmodule

// File: tb/tb_weight_stream_sink.sv
// Self-checking bench for weight_stream_sink (16-bit elements, 4 per word,
// 1 per beat, 3 words). A queue-based reference model predicts memory
// contents, handshake and done; a negedge monitor compares.
module tb_weight_stream_sink;

  localparam int unsigned MS = 3;

  logic        clk;
  logic        rst;
  logic [15:0] data_in [1];
  logic        data_in_valid;
  logic        data_in_ready;
  logic        load_start;
  logic        load_done;
  logic [2:0]  address0;
  logic        ce0;
  logic [63:0] q0;

  int n_checks;
  int n_err;

  weight_stream_sink #(
    .PRECISION_0      (16),
    .PARALLELISM_DIM_0(1),
    .PARALLELISM_DIM_1(1),
    .WORD_ELEMS       (4),
    .MEM_SIZE         (MS),
    .AWIDTH           (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .load_start   (load_start),
    .load_done    (load_done),
    .address0     (address0),
    .ce0          (ce0),
    .q0           (q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        known;
    logic [63:0] val;
  } rd_t;

  bit          filling;
  bit          done;
  logic [15:0] part [$];
  int unsigned waddr;
  logic [63:0] exp_mem [MS];
  bit          known [MS];
  rd_t         rq [$];   // rq[0] is what q0 must currently show

  task automatic model_reset();
    filling = 0;
    done    = 0;
    part.delete();
    waddr   = 0;
    for (int i = 0; i < MS; i++) known[i] = 0;
    rq.delete();
    rq.push_back('{known: 1'b1, val: 64'h0});
    rq.push_back('{known: 1'b1, val: 64'h0});
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      // read issued this edge sees memory before any write of this edge
      if (ce0) begin
        rd_t e;
        e.known = 1'b0;
        e.val   = '0;
        if (address0 < 3'(MS) && known[address0]) begin
          e.known = 1'b1;
          e.val   = exp_mem[address0];
        end
        rq.push_back(e);
        if (rq.size() > 2) void'(rq.pop_front());
      end
      if (load_start) begin
        filling = 1;
        done    = 0;
        part.delete();
        waddr   = 0;
      end else if (filling && data_in_valid) begin
        part.push_back(data_in[0]);
        if (part.size() == 4) begin
          logic [63:0] w;
          w = '0;
          for (int i = 0; i < 4; i++) w[16*i +: 16] = part[i];
          exp_mem[waddr] = w;
          known[waddr]   = 1;
          part.delete();
          if (waddr == MS - 1) begin
            waddr   = 0;
            filling = 0;
            done    = 1;
          end else begin
            waddr++;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("data_in_ready", 64'(data_in_ready), 64'(filling && !load_start));
      check("load_done", 64'(load_done), 64'(done));
      if (rq.size() > 0 && rq[0].known) check("q0", q0, rq[0].val);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [15:0] d, input logic ls,
                      input logic ce, input logic [2:0] a);
    data_in_valid = v;
    data_in[0]    = d;
    load_start    = ls;
    ce0           = ce;
    address0      = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < MS; a++) step(1'b0, 16'h0, 1'b0, 1'b1, 3'(a));
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd0);
    idle(1);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b0;
    data_in_valid = 1'b0;
    data_in[0]    = '0;
    load_start    = 1'b0;
    ce0           = 1'b0;
    address0      = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // idle: valid beats must be ignored
    for (int i = 0; i < 4; i++) step(1'b1, 16'h55, 1'b0, 1'b0, 3'd0);
    idle(2);

    // full fill, back-to-back
    step(1'b0, 16'h0, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 12; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 3'd0);
    idle(2);
    read_all();
    check("word0_direct", exp_mem[0], 64'h0004_0003_0002_0001);

    // same data with random valid gaps
    step(1'b0, 16'h0, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 12; ) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, 16'(i), 1'b0, 1'b0, 3'd0);
      if (v) i++;
    end
    idle(1);
    read_all();

    // restart mid-fill; coincident 0xFF beat must be dropped
    step(1'b0, 16'h0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'hA0 + 16'(i), 1'b0, 1'b0, 3'd0);
    step(1'b1, 16'hFF, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 16'hB0 + 16'(i), 1'b0, 1'b0, 3'd0);
    idle(1);
    read_all();
    check("restart_word0", exp_mem[0], 64'h00B3_00B2_00B1_00B0);

    // read-during-write: continuously read address 1 while refilling
    step(1'b0, 16'h0, 1'b1, 1'b1, 3'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 16'h10 + 16'(i), 1'b0, 1'b1, 3'd1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd1);
    idle(1);

    // ce0 stall: pipeline holds for 3 cycles
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 3'd1);
    idle(2);

    // asynchronous reset mid-fill
    step(1'b0, 16'h0, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h70 + 16'(i), 1'b0, 1'b1, 3'd0);
    data_in_valid = 1'b0;
    ce0           = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_ready", 64'(data_in_ready), 64'h0);
    check("rst_done", 64'(load_done), 64'h0);
    check("rst_q0", q0, 64'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h99, 1'b0, 1'b0, 3'd0);

    // randomized fills with random reads and occasional restarts
    for (int r = 0; r < 4; r++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 3'd0);
      for (int c = 0; c < 40; c++) begin
        step(1'($urandom_range(0, 3) != 0), 16'($urandom),
             1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3)));
      end
      read_all();
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
